// File: rtl/writeback.sv
// Writeback stage: aligns/extends load data and registers the register-file write port.
// Optional retired-instruction counter (output instret) enabled by defining WB_INSTRET_EN.
module writeback #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wb_valid,
    input  logic            wb_ld_regfile,
    input  logic            wb_is_load,
    input  logic [4:0]      wb_rd,
    input  logic [2:0]      wb_funct3,
    input  logic [1:0]      wb_addr_lo,
    input  logic [XLEN-1:0] wb_data,
    input  logic            dmem_resp,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            advance,
    output logic            ld_regfile,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] regfile_in,
`ifdef WB_INSTRET_EN
    output logic [63:0]     instret,
`endif
    output logic            misalign
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_next_state;

    logic [4:0]      r_cap_rd;
    logic            r_cap_ld;
    logic [2:0]      r_cap_funct3;
    logic [1:0]      r_cap_addr_lo;

    logic            w_retire;
    logic            w_is_load;
    logic            w_ld;
    logic [4:0]      w_rd;
    logic [2:0]      w_funct3;
    logic [1:0]      w_addr_lo;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_load_data;
    logic            w_misaligned;
    logic            w_capture;

    // In WAIT the write is driven from the captured context, not the (already advanced) inputs.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_next_state = r_state;
        advance      = 1'b0;
        w_retire     = 1'b0;
        w_capture    = 1'b0;
        w_is_load    = wb_is_load;
        w_ld         = wb_ld_regfile;
        w_rd         = wb_rd;
        w_funct3     = wb_funct3;
        w_addr_lo    = wb_addr_lo;
        case (r_state)
            IDLE: begin
                advance = !(wb_valid && wb_is_load && !dmem_resp);
                if (wb_valid) begin
                    if (!wb_is_load || dmem_resp) begin
                        w_retire = 1'b1;
                    end else begin
                        w_capture    = 1'b1;
                        w_next_state = WAIT;
                    end
                end
            end
            WAIT: begin
                w_is_load = 1'b1;
                w_ld      = r_cap_ld;
                w_rd      = r_cap_rd;
                w_funct3  = r_cap_funct3;
                w_addr_lo = r_cap_addr_lo;
                if (dmem_resp) begin
                    w_retire     = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign w_byte = dmem_rdata[8*w_addr_lo +: 8];
    assign w_half = w_addr_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    // funct3[1] set covers LW and the reserved encodings that behave as LW.
    always_comb begin
        w_load_data  = dmem_rdata;
        w_misaligned = 1'b0;
        if (w_funct3[1]) begin
            w_misaligned = (w_addr_lo != 2'b00);
        end else if (w_funct3[0]) begin
            w_misaligned = w_addr_lo[0];
            w_load_data  = w_funct3[2] ? {16'h0000, w_half} : {{16{w_half[15]}}, w_half};
        end else begin
            w_load_data  = w_funct3[2] ? {24'h000000, w_byte} : {{24{w_byte[7]}}, w_byte};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_cap_rd      <= '0;
            r_cap_ld      <= 1'b0;
            r_cap_funct3  <= '0;
            r_cap_addr_lo <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_capture) begin
                r_cap_rd      <= wb_rd;
                r_cap_ld      <= wb_ld_regfile;
                r_cap_funct3  <= wb_funct3;
                r_cap_addr_lo <= wb_addr_lo;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_regfile <= 1'b0;
            rd         <= '0;
            regfile_in <= '0;
            misalign   <= 1'b0;
        end else if (w_retire) begin
            ld_regfile <= w_ld && (w_rd != 5'd0) && !(w_is_load && w_misaligned);
            rd         <= w_rd;
            regfile_in <= w_is_load ? w_load_data : wb_data;
            misalign   <= w_is_load && w_misaligned;
        end else begin
            ld_regfile <= 1'b0;
            misalign   <= 1'b0;
        end
    end

`ifdef WB_INSTRET_EN
    logic [63:0] r_instret;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instret <= '0;
        end else if (w_retire) begin
            r_instret <= r_instret + 64'd1;
        end
    end

    assign instret = r_instret;
`endif

endmodule

// File: tb/tb_writeback.sv
// Randomised scoreboard bench for writeback: a cycle-level reference model pushes expected
// per-cycle outputs into a queue and a negedge monitor pops and compares them.
module tb_writeback;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_valid = 1'b0;
    logic        wb_ld_regfile = 1'b0;
    logic        wb_is_load = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [2:0]  wb_funct3 = '0;
    logic [1:0]  wb_addr_lo = '0;
    logic [31:0] wb_data = '0;
    logic        dmem_resp = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        advance;
    logic        ld_regfile;
    logic [4:0]  rd;
    logic [31:0] regfile_in;
    logic        misalign;
`ifdef WB_INSTRET_EN
    logic [63:0] instret;
`endif

    writeback #(.XLEN(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wb_valid      (wb_valid),
        .wb_ld_regfile (wb_ld_regfile),
        .wb_is_load    (wb_is_load),
        .wb_rd         (wb_rd),
        .wb_funct3     (wb_funct3),
        .wb_addr_lo    (wb_addr_lo),
        .wb_data       (wb_data),
        .dmem_resp     (dmem_resp),
        .dmem_rdata    (dmem_rdata),
        .advance       (advance),
        .ld_regfile    (ld_regfile),
        .rd            (rd),
        .regfile_in    (regfile_in),
`ifdef WB_INSTRET_EN
        .instret       (instret),
`endif
        .misalign      (misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          adv;
        bit          we;
        bit [4:0]    rd;
        bit [31:0]   data;
        bit          mis;
        bit [63:0]   cnt;
    } exp_t;

    exp_t expq[$];
    int   n_checks = 0;
    int   n_fail = 0;
    bit   done = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    bit        m_wait;
    bit [4:0]  m_cap_rd;
    bit        m_cap_ld;
    bit [2:0]  m_cap_f3;
    bit [1:0]  m_cap_addr;
    bit        m_we;
    bit [4:0]  m_rd;
    bit [31:0] m_data;
    bit        m_mis;
    bit [63:0] m_cnt;
    bit        do_preload = 0;

    function automatic bit [31:0] align(input bit [2:0] f3, input bit [1:0] a, input bit [31:0] w);
        longint b, h;
        b = (w >> (8 * a)) & 32'hFF;
        h = (w >> (16 * (a / 2))) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 128) ? 32'(b - 256) : 32'(b);
            3'b100:  return 32'(b);
            3'b001:  return (h >= 32768) ? 32'(h - 65536) : 32'(h);
            3'b101:  return 32'(h);
            default: return w;
        endcase
    endfunction

    function automatic bit is_mis(input bit [2:0] f3, input bit [1:0] a);
        if (f3 == 3'b001 || f3 == 3'b101) return (a % 2) != 0;
        if (f3 == 3'b000 || f3 == 3'b100) return 0;
        return a != 0;
    endfunction

    task automatic do_retire(input bit ld, input bit [4:0] r, input bit isl,
                             input bit [2:0] f3, input bit [1:0] a, input bit [31:0] d,
                             input bit [31:0] w);
        bit mis;
        mis    = isl && is_mis(f3, a);
        m_we   = ld && (r != 0) && !mis;
        m_rd   = r;
        m_data = isl ? align(f3, a, w) : d;
        m_mis  = mis;
        m_cnt  = m_cnt + 1;
    endtask

    // One clock cycle: drive inputs, push expected outputs for this cycle, advance the model.
    task automatic step(input bit rst, input bit v, input bit ld, input bit isl, input bit [4:0] r,
                        input bit [2:0] f3, input bit [1:0] a, input bit [31:0] d,
                        input bit resp, input bit [31:0] w);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rst; wb_valid = v; wb_ld_regfile = ld; wb_is_load = isl; wb_rd = r;
        wb_funct3 = f3; wb_addr_lo = a; wb_data = d; dmem_resp = resp; dmem_rdata = w;
        if (!rst) begin
            m_wait = 0; m_cap_rd = 0; m_cap_ld = 0; m_cap_f3 = 0; m_cap_addr = 0;
            m_we = 0; m_rd = 0; m_data = 0; m_mis = 0; m_cnt = 0;
        end
`ifdef WB_INSTRET_EN
        if (do_preload) begin
            dut.r_instret = 64'hFFFF_FFFF_FFFF_FFFF;
            m_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
            do_preload = 0;
        end
`endif
        e.adv  = !m_wait && !(v && isl && !resp);
        e.we   = m_we;
        e.rd   = m_rd;
        e.data = m_data;
        e.mis  = m_mis;
        e.cnt  = m_cnt;
        expq.push_back(e);
        if (rst) begin
            if (m_wait) begin
                if (resp) begin
                    do_retire(m_cap_ld, m_cap_rd, 1, m_cap_f3, m_cap_addr, d, w);
                    m_wait = 0;
                end else begin
                    m_we = 0; m_mis = 0;
                end
            end else if (v && (!isl || resp)) begin
                do_retire(ld, r, isl, f3, a, d, w);
            end else begin
                m_we = 0; m_mis = 0;
                if (v) begin
                    m_wait = 1; m_cap_rd = r; m_cap_ld = ld; m_cap_f3 = f3; m_cap_addr = a;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compares DUT outputs against the queued expectation every cycle.
    initial begin
        exp_t e;
        while (!done) begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                check("advance", advance, e.adv);
                check("ld_regfile", ld_regfile, e.we);
                check("misalign", misalign, e.mis);
                if (e.we) begin
                    check("rd", rd, e.rd);
                    check("regfile_in", regfile_in, e.data);
                end
`ifdef WB_INSTRET_EN
                check("instret", instret, e.cnt);
`endif
            end
        end
    end

    initial begin
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 5, 3'b010, 0, 32'h1, 1, 32'h2);
        idle(1);
        // Non-load to rd=5
        step(1, 1, 1, 0, 5, 0, 0, 32'h1234_5678, 0, 0);
        idle(1);
        // Hit load LB addr 3 -> 0xFFFFFF80
        step(1, 1, 1, 1, 7, 3'b000, 3, 0, 1, 32'h80AA_BBCC);
        idle(1);
        // Miss load LHU addr 2, response after 4 cycles
        step(1, 1, 1, 1, 9, 3'b101, 2, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 4, 0, 0, 32'hDEAD, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'hBEEF_0001);
        idle(2);
        // Misaligned LW and rd=0 non-load
        step(1, 1, 1, 1, 3, 3'b010, 1, 0, 1, 32'hCAFE_F00D);
        step(1, 1, 1, 0, 0, 0, 0, 32'h5555_AAAA, 0, 0);
        idle(1);
        // dmem_resp in IDLE without a load is ignored
        step(1, 0, 1, 1, 6, 0, 0, 0, 1, 32'h1111_2222);
        // Reset during WAIT, then a late response
        step(1, 1, 1, 1, 10, 3'b010, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h7777_7777);
        idle(1);
        // 10 back-to-back non-loads plus one miss load
        for (int i = 0; i < 10; i++) step(1, 1, 1, 0, 5'(i + 1), 0, 0, 32'(i * 3 + 100), 0, 0);
        step(1, 1, 1, 1, 12, 3'b010, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0BAD_BEEF);
        idle(1);
`ifdef WB_INSTRET_EN
        do_preload = 1;
        idle(1);
        step(1, 1, 1, 0, 2, 0, 0, 32'h42, 0, 0);
        idle(1);
`endif
        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            bit [4:0] r;
            r = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            step(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0), 1'($urandom),
                 1'($urandom), r, 3'($urandom), 2'($urandom), $urandom,
                 1'($urandom), $urandom);
        end
        idle(2);
        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", expq.size(), 0);
        done = 1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
